// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage.
//   INSTR_W        : instruction word width (32-bit MIPS words)
//   FETCH_ADDR_W   : default byte-address width of the instruction memory
//   FETCH_RESET_PC : default first fetch address after reset (word-aligned)
//   FIFO_DEPTH     : number of {pc, instr} entries buffered toward decode
//   fetch_entry_t  : one buffered instruction with the address it came from
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int INSTR_W      = 32;
  localparam int FETCH_ADDR_W = 8;
  localparam int FIFO_DEPTH   = 2;

  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [INSTR_W-1:0]      instr;
  } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Two-entry first-word-fall-through buffer between the instruction memory
// response and the decode handshake. Push and pop may happen in the same
// cycle; flush empties the buffer and takes priority over a push.
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   push      : write push_data this cycle
//   push_data : entry to store
//   pop       : consumer takes the head entry this cycle
//   flush     : discard every stored entry (and any push this cycle)
//   head      : oldest stored entry (meaningful only while count != 0)
//   count     : number of stored entries, 0..2
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  input  logic       flush,
  output entry_t     head,
  output logic [1:0] count
);

  localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       do_push;
  logic       do_pop;

  // A pop on an empty buffer is ignored; a push into a full buffer is only
  // legal when the head leaves in the same cycle.
  assign do_pop  = pop && !flush && (count_reg != 2'd0);
  assign do_push = push && !flush && ((count_reg != FULL_COUNT) || do_pop);

  // Storage: one register per slot, written when the write pointer selects it.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    entry_t data_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_reg <= '0;
      end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
        data_reg <= push_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + 2'(do_push) - 2'(do_pop);
    end
  end

  assign head  = rd_ptr_reg ? g_slot[1].data_reg : g_slot[0].data_reg;
  assign count = count_reg;

  // The upstream request rule must never let a response arrive into a full
  // buffer that is not draining this cycle.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (reset)
      !(push && !flush && (count_reg == FULL_COUNT) && !(pop && (count_reg != 2'd0)))
  );

endmodule : fetch_fifo

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage of the MIPS core. Owns the program counter, issues word reads
// to a byte-addressed instruction memory with one cycle of read latency and
// hands big-endian instructions plus their PC to decode over valid/ready.
// A 2-entry buffer absorbs decode back-pressure while sustaining one
// instruction per cycle. Branch/jump redirects override sequential fetch.
//
// Ports
//   clk            : clock, rising edge
//   reset          : asynchronous active-high reset
//   imem_req       : instruction memory read request this cycle
//   imem_addr      : word-aligned byte address of the request
//   imem_rdata     : read data, valid the cycle after imem_req (big-endian)
//   redirect_valid : taken branch/jump; new stream starts at redirect_pc
//   redirect_pc    : redirect target, low two bits ignored
//   if_valid       : if_instr / if_pc / if_pc_plus4 are valid
//   if_ready       : decode accepts the presented instruction
//   if_instr       : instruction word
//   if_pc          : address of if_instr
//   if_pc_plus4    : if_pc + 4, wrapping at the address width
// -----------------------------------------------------------------------------
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc_reg;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic              run_reg;
  logic              inflight_reg;
  logic [ADDR_W-1:0] inflight_pc_reg;

  logic              pop;
  logic              push;
  entry_t            push_entry;
  entry_t            head;
  logic [1:0]        count;
  logic [2:0]        occupancy;

  // ---------------------------------------------------------------------------
  // Request rule: entries already buffered plus the response still in flight,
  // minus the one decode takes this cycle, must leave room for one more.
  // ---------------------------------------------------------------------------
  assign pop       = if_valid && if_ready;
  assign occupancy = {1'b0, count} + {2'b00, inflight_reg} - {2'b00, pop};
  assign imem_req  = run_reg && !redirect_valid && (occupancy < 3'd2);
  assign imem_addr = fetch_pc_reg;

  // A response landing in a redirect cycle belongs to the abandoned stream.
  assign push             = inflight_reg && !redirect_valid;
  assign push_entry.pc    = inflight_pc_reg;
  assign push_entry.instr = imem_rdata;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc & ALIGN_MASK;
    end else if (imem_req) begin
      fetch_pc_next = fetch_pc_reg + WORD_BYTES;
    end
  end

  // run_reg holds fetch off for the first edge after reset release so the
  // first request appears one cycle after that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      run_reg         <= 1'b0;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      run_reg      <= 1'b1;
      inflight_reg <= imem_req;
      if (imem_req) begin
        inflight_pc_reg <= fetch_pc_reg;
      end
    end
  end

  fetch_fifo #(
    .entry_t (entry_t)
  ) u_fetch_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  // Outputs read as zero whenever nothing is presented, so stale buffer
  // contents never leak toward decode.
  assign if_valid    = (count != 2'd0);
  assign if_instr    = if_valid ? head.instr : '0;
  assign if_pc       = if_valid ? head.pc : '0;
  assign if_pc_plus4 = if_valid ? (head.pc + WORD_BYTES) : '0;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed and randomized stimulus for instruction_fetch. The reference model
// is the program-order stream: every presented instruction must carry the
// next expected PC and the big-endian word stored there; a redirect restarts
// the expected stream at the aligned target.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic [7:0]  if_pc_plus4;

  instruction_fetch #(
    .ADDR_W   (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  always #5 clk = ~clk;

  // Byte-addressed instruction memory with one cycle of read latency.
  logic [7:0] mem [256];

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {mem[a], mem[a1], mem[a2], mem[a3]};
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= word_at(imem_addr);
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          starve = 0;
  logic [7:0]  exp_pc = 8'h00;
  logic        l_valid, l_req;
  logic [7:0]  l_addr, l_pc, l_p4;
  logic [31:0] l_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, sample 1 ns later,
  // advance the reference stream at the rising edge.
  task automatic tick(input logic rdy, input logic rv, input logic [7:0] rpc);
    logic [7:0] p4;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    l_valid = if_valid;
    l_req   = imem_req;
    l_addr  = imem_addr;
    l_instr = if_instr;
    l_pc    = if_pc;
    l_p4    = if_pc_plus4;
    p4      = exp_pc + 8'd4;
    $display("cyc t=%0t rdy=%0b redir=%0b/%h req=%0b addr=%h valid=%0b pc=%h instr=%h",
             $time, rdy, rv, rpc, l_req, l_addr, l_valid, l_pc, l_instr);
    if (l_valid === 1'b1) begin
      check("if_pc", 32'(l_pc), 32'(exp_pc));
      check("if_instr", l_instr, word_at(exp_pc));
      check("if_pc_plus4", 32'(l_p4), 32'(p4));
    end
    if (rv) check("no_req_on_redirect", 32'(l_req), 32'h0);
    if (l_req === 1'b1) check("addr_aligned", 32'(l_addr[1:0]), 32'h0);
    if (rv) starve = 0;
    else if (rdy && (l_valid !== 1'b1)) starve++;
    else starve = 0;
    check("bubble_bound", 32'(starve > 3), 32'h0);
    @(posedge clk);
    if (rv) exp_pc = {rpc[7:2], 2'b00};
    else if ((l_valid === 1'b1) && rdy) exp_pc = exp_pc + 8'd4;
    @(negedge clk);
  endtask

  // Reset release at a falling edge; C0 is the cycle before E1.
  task automatic startup(input string tag);
    exp_pc = 8'h00;
    tick(1'b1, 1'b0, 8'h00);
    check({tag, "_c0_req"}, 32'(l_req), 32'h0);
    tick(1'b1, 1'b0, 8'h00);
    check({tag, "_c1_req"}, 32'(l_req), 32'h1);
    check({tag, "_c1_addr"}, 32'(l_addr), 32'h00);
    check({tag, "_c1_valid"}, 32'(l_valid), 32'h0);
    tick(1'b1, 1'b0, 8'h00);
    check({tag, "_c2_req"}, 32'(l_req), 32'h1);
    check({tag, "_c2_addr"}, 32'(l_addr), 32'h04);
    check({tag, "_c2_valid"}, 32'(l_valid), 32'h0);
    tick(1'b1, 1'b0, 8'h00);
    check({tag, "_c3_valid"}, 32'(l_valid), 32'h1);
    check({tag, "_c3_instr"}, l_instr, 32'h200a000a);
    check({tag, "_c3_pc"}, 32'(l_pc), 32'h00);
    check({tag, "_c3_pc_plus4"}, 32'(l_p4), 32'h04);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(if_valid), 32'h0);
    check({tag, "_req"}, 32'(imem_req), 32'h0);
    check({tag, "_addr"}, 32'(imem_addr), 32'h00);
    check({tag, "_instr"}, if_instr, 32'h0);
    check({tag, "_pc"}, 32'(if_pc), 32'h00);
    check({tag, "_pc_plus4"}, 32'(if_pc_plus4), 32'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h20;
    mem[1] = 8'h0a;
    mem[2] = 8'h00;
    mem[3] = 8'h0a;

    // Reset state and first fetch.
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    startup("boot");

    // Sequential stream with decode always ready: no gaps.
    for (int k = 1; k < 8; k++) begin
      tick(1'b1, 1'b0, 8'h00);
      check("seq_valid", 32'(l_valid), 32'h1);
      check("seq_pc", 32'(l_pc), 32'(4 * k));
    end

    // Decode stalls for 5 cycles: requests stop once two entries are owed.
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b0, 8'h00);
      check("stall_req", 32'(l_req), 32'h0);
      check("stall_valid", 32'(l_valid), 32'h1);
    end
    tick(1'b1, 1'b0, 8'h00);
    check("resume_req", 32'(l_req), 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0, 8'h00);
      check("resume_valid", 32'(l_valid), 32'h1);
    end

    // Redirect to an unaligned target while a request is in flight.
    tick(1'b1, 1'b1, 8'h43);
    tick(1'b1, 1'b0, 8'h00);
    check("redir_n1_valid", 32'(l_valid), 32'h0);
    check("redir_n1_req", 32'(l_req), 32'h1);
    check("redir_n1_addr", 32'(l_addr), 32'h40);
    tick(1'b1, 1'b0, 8'h00);
    check("redir_n2_valid", 32'(l_valid), 32'h0);
    tick(1'b1, 1'b0, 8'h00);
    check("redir_n3_valid", 32'(l_valid), 32'h1);
    check("redir_n3_pc", 32'(l_pc), 32'h40);

    // Redirect to the last word: PC wraps to 0.
    tick(1'b1, 1'b1, 8'hFC);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    check("wrap_pc", 32'(l_pc), 32'hFC);
    check("wrap_pc_plus4", 32'(l_p4), 32'h00);
    tick(1'b1, 1'b0, 8'h00);
    check("wrap_next_pc", 32'(l_pc), 32'h00);
    check("wrap_next_pc_plus4", 32'(l_p4), 32'h04);

    // Random back-pressure and redirects against the stream model.
    for (int k = 0; k < 400; k++) begin
      tick(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 19) == 0), 8'($urandom));
    end
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 8'h00);

    // Fill the buffer, then assert reset between clock edges.
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 8'h00);
    check("full_before_reset", 32'(l_valid), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    startup("reboot");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the MIPS core: owns the program counter, issues word reads to the byte-addressed instruction memory, and delivers big-endian 32-bit instructions with their PC to the decode stage over a valid/ready handshake. It sits directly upstream of decode/ALU and accepts PC redirects from branch/jump resolution. A 2-entry buffer decouples memory latency from decode back-pressure and sustains one instruction per cycle.

## Interface

- ADDR_W, 8, byte-address width (256-byte instruction memory).
- RESET_PC, 0, first fetch address after reset; must be word-aligned.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  word-aligned byte address of request (bits 1:0 always 0).
- imem_rdata  in  32  read data, valid exactly one cycle after imem_req; byte at imem_addr in bits 31:24, addr+3 in bits 7:0.
- redirect_valid  in  1  branch/jump taken; overrides sequential fetch.
- redirect_pc  in  ADDR_W  new PC; bits 1:0 ignored (forced to 0).
- if_valid  out  1  if_instr/if_pc valid.
- if_ready  in  1  decode accepts this cycle.
- if_instr  out  32  instruction word.
- if_pc  out  ADDR_W  address of if_instr.
- if_pc_plus4  out  ADDR_W  if_pc + 4, modulo 2^ADDR_W.

## Operation

- State: fetch_pc, run flag, inflight flag + inflight_pc, 2-entry FIFO of {pc, instr}, count 0..2.
- Reset values: fetch_pc = RESET_PC, run = 0, inflight = 0, count = 0; outputs imem_req = 0, imem_addr = RESET_PC, if_valid = 0, if_instr = 0, if_pc = 0, if_pc_plus4 = 0.
- pop = if_valid && if_ready.
- imem_req = run && !redirect_valid && (count + inflight − pop < 2). imem_addr = fetch_pc.
- On imem_req: fetch_pc ← fetch_pc + 4 (wraps 0xFC → 0x00); inflight ← 1, inflight_pc ← fetch_pc. Otherwise inflight ← 0.
- When inflight is set, the imem_rdata of that cycle is pushed with inflight_pc. Push and pop in the same cycle are both allowed; count never exceeds 2 (guaranteed by the request rule, and an assertion checks it).
- FIFO head drives if_instr/if_pc/if_pc_plus4; if_valid = (count != 0). Order strictly preserved.
- Redirect (highest priority): fetch_pc ← {redirect_pc[ADDR_W-1:2], 2'b00}, FIFO cleared, in-flight response of this cycle discarded, no request this cycle. A handshake completing in the redirect cycle counts as consumed; nothing else from the old stream is ever presented afterwards.
- Reset mid-operation: all outputs return to reset values asynchronously; fetch restarts at RESET_PC.

## Timing

- E1 = first rising edge with reset low: run ← 1. C1: imem_req = 1, addr RESET_PC.
- C2: data for RESET_PC on imem_rdata; request for RESET_PC+4.
- C3: if_valid = 1 with first instruction (fetch-to-decode latency 2 cycles from request).
- if_ready held high: one instruction per cycle steady state, no bubbles.
- if_ready low: FIFO fills to 2, imem_req drops in the cycle count + inflight reaches 2; resumes the cycle a pop frees room.
- Redirect in cycle N: request to the new PC in N+1, if_valid for it in N+3; if_valid = 0 in N+1 and N+2.

## Structure

- Package fetch_pkg: INSTR_W = 32, default ADDR_W, RESET_PC, fifo entry struct {pc, instr}.
- One sub-module: fetch_fifo (2-entry, parameterized entry type, push/pop/flush, count output).
- instruction_fetch holds PC, run, in-flight tracking and request logic.

## Test plan

- Reset release, memory bytes 0..3 = 20 0a 00 0a -> C3: if_valid = 1, if_instr = 32'h200a000a, if_pc = 0x00, if_pc_plus4 = 0x04.
- Sequential fetch, if_ready = 1, words at 0x00..0x1C -> eight consecutive cycles of if_valid with pcs 0x00..0x1C, no gaps.
- if_ready low for 5 cycles mid-stream -> imem_req low once 2 entries held, no instruction lost or duplicated, order intact on release.
- redirect_valid with redirect_pc = 0x43 while a request is in flight -> if_valid low 2 cycles, next instruction has if_pc = 0x40; no stale word appears.
- redirect_pc = 0xFC -> pcs 0xFC then 0x00 (if_pc_plus4 = 0x00 for 0xFC).
- Assert reset asynchronously mid-clock with a full FIFO -> if_valid and imem_req drop immediately; after release the first instruction is again from RESET_PC at C3.
